// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
// No logic; the parity helper is a pure combinational function.
// Not applicable: no flow control lives in this file.
package router_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HEAD,
        PAY,
        PAR,
        RESP
    } tx_state_t;

    localparam logic [1:0] ADDR_ILLEGAL = 2'b11;
    localparam int         HDR_LEN_MSB  = 7;
    localparam int         HDR_LEN_LSB  = 2;
    localparam int         MAX_LEN      = 63;
    localparam int         FIFO_DEPTH   = 64;
    localparam int         FIFO_AW      = 6;

    function automatic logic [7:0] parity_update(input logic [7:0] par, input logic [7:0] dat);
        return par ^ dat;
    endfunction

endpackage

// File: rtl/tx_payload_fifo.sv
// 64x8 payload buffer with look-ahead read (o_dat shows the head entry).
// Latency: a pushed byte is visible at o_dat one cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored.
module tx_payload_fifo
    import router_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       i_push,
    input  logic [7:0] i_dat,
    input  logic       i_pop,
    output logic [7:0] o_dat,
    output logic       o_full,
    output logic       o_empty
);

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == (FIFO_AW+1)'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_dat     = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Router source-side packet transmitter: buffers a payload, then sends header, payload, parity.
// Latency: header appears the cycle after the last payload byte is loaded; all outputs registered.
// Backpressure: busy=1 holds pkt_data/pkt_valid; pay_ready/req_ready are registered handshakes.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int LEN_W    = 6,
    parameter int ERR_WAIT = 3
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             req_valid,
    input  logic [1:0]       req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic             inj_err,
    output logic             req_ready,
    input  logic             pay_valid,
    input  logic [7:0]       pay_data,
    output logic             pay_ready,
    input  logic             busy,
    input  logic             err,
    output logic [7:0]       pkt_data,
    output logic             pkt_valid,
    output logic             tx_active,
    output logic             tx_done,
    output logic             tx_err,
    output logic             tx_drop
);

    localparam int WAIT_W = $clog2(ERR_WAIT + 1);

    tx_state_t          r_state,     w_state_nxt;
    logic [1:0]         r_addr,      w_addr_nxt;
    logic [LEN_W-1:0]   r_len,       w_len_nxt;
    logic               r_inj,       w_inj_nxt;
    logic [LEN_W-1:0]   r_cnt,       w_cnt_nxt;
    logic [7:0]         r_parity,    w_parity_nxt;
    logic               r_flag,      w_flag_nxt;
    logic [WAIT_W-1:0]  r_wait,      w_wait_nxt;
    logic [7:0]         r_pkt_data,  w_pkt_data_nxt;
    logic               r_pkt_valid, w_pkt_valid_nxt;
    logic               r_req_ready, w_req_ready_nxt;
    logic               r_pay_ready, w_pay_ready_nxt;
    logic               r_tx_active;
    logic               r_tx_done,   w_tx_done_nxt;
    logic               r_tx_err,    w_tx_err_nxt;
    logic               r_tx_drop,   w_tx_drop_nxt;

    logic [LEN_W-1:0]   w_cnt_inc;
    logic [7:0]         w_hdr;
    logic [7:0]         w_par_last;
    logic               w_fifo_push;
    logic               w_fifo_pop;
    logic [7:0]         w_fifo_dat;
    logic               w_fifo_full;
    logic               w_fifo_empty;

    tx_payload_fifo u_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .i_push  (w_fifo_push),
        .i_dat   (pay_data),
        .i_pop   (w_fifo_pop),
        .o_dat   (w_fifo_dat),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_par_last = parity_update(r_parity, r_pkt_data) ^ {8{r_inj}};

    always_comb begin
        w_hdr = '0;
        w_hdr[HDR_LEN_MSB:HDR_LEN_LSB] = r_len;
        w_hdr[HDR_LEN_LSB-1:0]         = r_addr;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_len_nxt       = r_len;
        w_inj_nxt       = r_inj;
        w_cnt_nxt       = r_cnt;
        w_parity_nxt    = r_parity;
        w_flag_nxt      = r_flag;
        w_wait_nxt      = r_wait;
        w_pkt_data_nxt  = r_pkt_data;
        w_pkt_valid_nxt = r_pkt_valid;
        w_req_ready_nxt = 1'b0;
        w_pay_ready_nxt = 1'b0;
        w_tx_done_nxt   = 1'b0;
        w_tx_err_nxt    = 1'b0;
        w_tx_drop_nxt   = 1'b0;
        w_fifo_push     = 1'b0;
        w_fifo_pop      = 1'b0;

        case (r_state)
            IDLE: begin
                // A request held across the registered ready is consumed only once.
                if (req_valid && !r_req_ready) begin
                    w_req_ready_nxt = 1'b1;
                    if (req_addr == ADDR_ILLEGAL || req_len == '0) begin
                        w_tx_drop_nxt = 1'b1;
                    end else begin
                        w_addr_nxt      = req_addr;
                        w_len_nxt       = req_len;
                        w_inj_nxt       = inj_err;
                        w_cnt_nxt       = '0;
                        w_pay_ready_nxt = 1'b1;
                        w_state_nxt     = LOAD;
                    end
                end
            end
            LOAD: begin
                w_pay_ready_nxt = r_pay_ready;
                if (pay_valid && r_pay_ready) begin
                    w_fifo_push = !w_fifo_full;
                    w_cnt_nxt   = w_cnt_inc;
                    if (w_cnt_inc == r_len) begin
                        w_pay_ready_nxt = 1'b0;
                        w_cnt_nxt       = '0;
                        w_pkt_data_nxt  = w_hdr;
                        w_pkt_valid_nxt = 1'b1;
                        w_parity_nxt    = w_hdr;
                        w_state_nxt     = HEAD;
                    end
                end
            end
            HEAD: begin
                // Bytes leave the FIFO as they are loaded into the output register.
                if (!busy) begin
                    w_fifo_pop     = !w_fifo_empty;
                    w_pkt_data_nxt = w_fifo_dat;
                    w_state_nxt    = PAY;
                end
            end
            PAY: begin
                if (!busy) begin
                    w_parity_nxt = parity_update(r_parity, r_pkt_data);
                    w_cnt_nxt    = w_cnt_inc;
                    if (w_cnt_inc == r_len) begin
                        w_pkt_valid_nxt = 1'b0;
                        w_pkt_data_nxt  = w_par_last;
                        w_state_nxt     = PAR;
                    end else begin
                        w_fifo_pop     = !w_fifo_empty;
                        w_pkt_data_nxt = w_fifo_dat;
                    end
                end
            end
            PAR: begin
                if (!busy) begin
                    w_pkt_data_nxt = '0;
                    w_wait_nxt     = '0;
                    w_flag_nxt     = 1'b0;
                    w_state_nxt    = RESP;
                end
            end
            RESP: begin
                w_flag_nxt = r_flag | err;
                w_wait_nxt = r_wait + 1'b1;
                if (r_wait == WAIT_W'(ERR_WAIT - 1)) begin
                    w_tx_done_nxt = 1'b1;
                    w_tx_err_nxt  = r_flag | err;
                    w_state_nxt   = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_inj       <= 1'b0;
            r_cnt       <= '0;
            r_parity    <= '0;
            r_flag      <= 1'b0;
            r_wait      <= '0;
            r_pkt_data  <= '0;
            r_pkt_valid <= 1'b0;
            r_req_ready <= 1'b0;
            r_pay_ready <= 1'b0;
            r_tx_active <= 1'b0;
            r_tx_done   <= 1'b0;
            r_tx_err    <= 1'b0;
            r_tx_drop   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_len       <= w_len_nxt;
            r_inj       <= w_inj_nxt;
            r_cnt       <= w_cnt_nxt;
            r_parity    <= w_parity_nxt;
            r_flag      <= w_flag_nxt;
            r_wait      <= w_wait_nxt;
            r_pkt_data  <= w_pkt_data_nxt;
            r_pkt_valid <= w_pkt_valid_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_pay_ready <= w_pay_ready_nxt;
            r_tx_active <= (w_state_nxt != IDLE);
            r_tx_done   <= w_tx_done_nxt;
            r_tx_err    <= w_tx_err_nxt;
            r_tx_drop   <= w_tx_drop_nxt;
        end
    end

    assign req_ready = r_req_ready;
    assign pay_ready = r_pay_ready;
    assign pkt_data  = r_pkt_data;
    assign pkt_valid = r_pkt_valid;
    assign tx_active = r_tx_active;
    assign tx_done   = r_tx_done;
    assign tx_err    = r_tx_err;
    assign tx_drop   = r_tx_drop;

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
- Packet transmitter (source side) for the 1x3 router input port. It drives the router's data_in/pkt_valid inputs and honours the router's busy back-pressure.
- Accepts a transmit request (destination address, payload length) and buffers the full payload locally. It then emits header, payload and parity bytes back-to-back and samples the router's err response.
- Sits between the traffic source (test or host logic) and the router top level. It is the initiator counterpart of the router's input FSM/register path.

Parameters:
- LEN_W, 6, payload-length field width (header bits [7:2]).
- ERR_WAIT, 3, cycles after parity acceptance during which err is sampled.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  transmit request present.
- req_addr  in  2  destination port (0..2; 3 is illegal).
- req_len  in  LEN_W  payload byte count (1..63; 0 is illegal).
- inj_err  in  1  invert parity byte for this packet (sampled with request).
- req_ready  out  1  request accepted this cycle.
- pay_valid  in  1  payload byte present.
- pay_data  in  8  payload byte.
- pay_ready  out  1  payload byte accepted this cycle.
- busy  in  1  router back-pressure; hold current byte.
- err  in  1  router parity-error indication.
- pkt_data  out  8  byte to router data_in.
- pkt_valid  out  1  high for header+payload, low for parity byte.
- tx_active  out  1  packet in progress (state != IDLE).
- tx_done  out  1  one-cycle pulse at end of RESP.
- tx_err  out  1  valid with tx_done; err seen in window.
- tx_drop  out  1  one-cycle pulse, illegal request discarded.

Behaviour:
- Reset (async, resetn=0): state IDLE.
  - All outputs 0: pkt_data=8'h00, pkt_valid=0, req_ready=0, pay_ready=0, tx_*=0.
  - Buffer cleared, byte counters and parity register 0.
- All outputs are registered.
- Byte transfer rule: a byte presented on pkt_data counts as accepted on a rising edge where busy=0. While busy=1, pkt_data and pkt_valid hold unchanged.
- IDLE:
  - req_ready=1 whenever req_valid=1.
  - If req_addr==3 or req_len==0: pulse tx_drop and stay in IDLE.
  - Otherwise latch addr, len and inj_err, then go to LOAD.
- LOAD:
  - pay_ready=1 until len bytes have been written into tx_payload_fifo.
  - On the len-th accepted byte, go to HEAD; pay_ready drops the same cycle the counter reaches len.
- HEAD:
  - pkt_data={len,addr}, pkt_valid=1, parity<=header byte.
  - On acceptance, go to PAY.
- PAY:
  - pkt_data is the FIFO head byte, pkt_valid=1.
  - On each acceptance, pop the FIFO, parity^=byte, count++.
  - After len accepted bytes, go to PAR.
  - The FIFO read is look-ahead, so consecutive bytes are emitted with no bubble when busy=0.
- PAR:
  - pkt_data=parity (or ~parity if inj_err), pkt_valid=0.
  - On acceptance, go to RESP.
- RESP:
  - pkt_valid=0, pkt_data=0. Count ERR_WAIT cycles, OR-ing err into a sticky flag.
  - On the final cycle, pulse tx_done with tx_err=flag, then go to IDLE.
  - A new request is not accepted before the first IDLE cycle.
- Throughput: a packet of length N with no busy occupies N cycles in LOAD (if pay_valid is continuous), 1 in HEAD, N in PAY, 1 in PAR and ERR_WAIT in RESP.
- busy asserted on the HEAD cycle: the header is held and the FSM stays in HEAD.
- busy on the final payload byte: the byte is held and the PAR transition is deferred.
- pay_valid gaps in LOAD only stall LOAD; they never create pkt_valid gaps.
- Reset mid-packet: immediate return to IDLE, buffer flushed, pkt_valid=0; no tx_done is issued.
- FIFO overflow is impossible by construction (depth 64 ≥ max len). Overflow or underflow of the FIFO is a design error; the verifier asserts it never occurs.

Decomposition:
- Package router_pkg:
  - tx state enum (IDLE, LOAD, HEAD, PAY, PAR, RESP).
  - Constants: ADDR_ILLEGAL=2'b11, HDR_LEN_MSB=7, HDR_LEN_LSB=2, MAX_LEN=63.
  - Function for parity update.
- Sub-module tx_payload_fifo: 64x8 synchronous FIFO with push/pop, full/empty, async active-low reset on clock/resetn, and look-ahead output.

Test Plan:
1. addr=1, len=4, payload 11,22,33,44, busy=0: pkt_data sequence is 8'h11 (header), 11, 22, 33, 44, then parity 8'h55 with pkt_valid low; tx_done after 3 RESP cycles with tx_err=0.
2. Same packet with busy=1 for 2 cycles on the 2nd payload byte: byte 8'h22 held 3 cycles; total sequence and parity unchanged.
3. addr=3 len=5, then addr=0 len=0: tx_drop pulses once per request; pkt_valid never rises; pay_ready stays 0.
4. addr=2, len=63 with pay_valid toggling every cycle: LOAD takes 126 cycles; PAY emits 63 contiguous pkt_valid=1 cycles; parity equals the XOR of all 64 bytes.
5. inj_err=1 with a router model raising err 2 cycles after parity: parity byte is inverted; tx_done coincides with tx_err=1.
6. resetn dropped mid-PAY: all outputs go to 0 asynchronously; the next request starts cleanly with a correct header.
